// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 instruction fields into a 32-bit word after range-checking
// the immediate for its format, then streams words to instruction memory with sequential addresses.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd_addr,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic              err_flag,
    output logic [7:0]        err_cnt
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_next;
    logic        legal;
    logic [31:0] word;
    logic        accept, take, reject, fire;

    // Per-format packing and immediate range check; unknown opcodes stay illegal.
    always_comb begin
        legal = 1'b0;
        word  = 32'h0;
        case (opcode)
            OP_R: begin
                legal = 1'b1;
                word  = {funct7, rs2_addr, rs1_addr, funct3, rd_addr, opcode};
            end
            OP_ITYPE: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    legal = (imm[31:5] == 27'h0);
                    word  = {funct7, imm[4:0], rs1_addr, funct3, rd_addr, opcode};
                end else begin
                    legal = (imm[31:11] == {21{imm[11]}});
                    word  = {imm[11:0], rs1_addr, funct3, rd_addr, opcode};
                end
            end
            OP_LOAD, OP_FLW, OP_JALR: begin
                legal = (imm[31:11] == {21{imm[11]}});
                word  = {imm[11:0], rs1_addr, funct3, rd_addr, opcode};
            end
            OP_STORE, OP_FSW: begin
                legal = (imm[31:11] == {21{imm[11]}});
                word  = {imm[11:5], rs2_addr, rs1_addr, funct3, imm[4:0], opcode};
            end
            OP_BRANCH: begin
                legal = (imm[31:12] == {20{imm[12]}}) && !imm[0];
                word  = {imm[12], imm[10:5], rs2_addr, rs1_addr, funct3, imm[4:1], imm[11], opcode};
            end
            OP_LUI, OP_AUIPC: begin
                legal = (imm[11:0] == 12'h0);
                word  = {imm[31:12], rd_addr, opcode};
            end
            OP_JAL: begin
                legal = (imm[31:20] == {12{imm[20]}}) && !imm[0];
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd_addr, opcode};
            end
            default: ;
        endcase
    end

    // out_valid is masked during rst so no memory write can complete in that cycle.
    assign out_valid = (state == FULL) && !rst;
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign take      = accept && legal;
    assign reject    = accept && !legal;
    assign fire      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (take) state_next = FULL;
            FULL: begin
                if (take)           state_next = FULL;
                else if (out_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)       im_wdata <= 32'h0;
        else if (take) im_wdata <= word;
    end

    // restart takes priority over an address advance in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || restart) im_addr <= BASE;
        else if (fire)      im_addr <= im_addr + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            err_flag <= 1'b0;
            err_cnt  <= 8'h0;
        end else if (reject) begin
            err_flag <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table, hand-written handshake/restart/reset sequences, and a
// randomized run scored by decoding im_wdata back into fields.
`timescale 1ns/1ps
module tb_instr_encoder;
    localparam logic [31:0] BASE_ADDR = 32'hFFFF_FFF0;
    localparam int          ADDR_W    = 32;

    localparam int F_BAD = 0, F_R = 1, F_I = 2, F_SH = 3, F_S = 4, F_B = 5, F_U = 6, F_J = 7;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        fields_t     f;
        bit          ok;
        logic [31:0] word;
        string       name;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst, restart, in_valid, in_ready, out_valid, out_ready, err_flag;
    logic [6:0]        opcode, funct7;
    logic [4:0]        rd_addr, rs1_addr, rs2_addr;
    logic [2:0]        funct3;
    logic [31:0]       imm, im_wdata;
    logic [ADDR_W-1:0] im_addr;
    logic [7:0]        err_cnt;

    int tests  = 0;
    int failed = 0;

    instr_encoder #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .im_wdata(im_wdata), .im_addr(im_addr),
        .err_flag(err_flag), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int fmt_of(logic [6:0] op, logic [2:0] f3);
        case (op)
            7'b0110011:                         return F_R;
            7'b0010011:                         return (f3 == 3'd1 || f3 == 3'd5) ? F_SH : F_I;
            7'b0000011, 7'b0000111, 7'b1100111: return F_I;
            7'b0100011, 7'b0100111:             return F_S;
            7'b1100011:                         return F_B;
            7'b0110111, 7'b0010111:             return F_U;
            7'b1101111:                         return F_J;
            default:                            return F_BAD;
        endcase
    endfunction

    // Legality expressed as numeric ranges of the signed immediate.
    function automatic bit legal_model(fields_t f);
        int signed v;
        v = $signed(f.imm);
        case (fmt_of(f.opcode, f.funct3))
            F_R:      return 1'b1;
            F_I, F_S: return (v >= -2048) && (v <= 2047);
            F_SH:     return f.imm < 32;
            F_B:      return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
            F_J:      return (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
            F_U:      return (f.imm % 4096) == 0;
            default:  return 1'b0;
        endcase
    endfunction

    // Keeps only the fields a format actually carries.
    function automatic fields_t canon(fields_t f);
        fields_t c;
        c = '0;
        c.opcode = f.opcode;
        case (fmt_of(f.opcode, f.funct3))
            F_R:      begin c.rd = f.rd; c.rs1 = f.rs1; c.rs2 = f.rs2; c.funct3 = f.funct3; c.funct7 = f.funct7; end
            F_I:      begin c.rd = f.rd; c.rs1 = f.rs1; c.funct3 = f.funct3; c.imm = f.imm; end
            F_SH:     begin c.rd = f.rd; c.rs1 = f.rs1; c.funct3 = f.funct3; c.funct7 = f.funct7; c.imm = f.imm; end
            F_S, F_B: begin c.rs1 = f.rs1; c.rs2 = f.rs2; c.funct3 = f.funct3; c.imm = f.imm; end
            F_U, F_J: begin c.rd = f.rd; c.imm = f.imm; end
            default:  ;
        endcase
        return c;
    endfunction

    function automatic fields_t decode(logic [31:0] w);
        fields_t d;
        d = '0;
        d.opcode = w[6:0];
        case (fmt_of(w[6:0], w[14:12]))
            F_R: begin
                d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = w[14:12]; d.funct7 = w[31:25];
            end
            F_I: begin
                d.rd = w[11:7]; d.rs1 = w[19:15]; d.funct3 = w[14:12]; d.imm = {{20{w[31]}}, w[31:20]};
            end
            F_SH: begin
                d.rd = w[11:7]; d.rs1 = w[19:15]; d.funct3 = w[14:12]; d.funct7 = w[31:25];
                d.imm = {27'h0, w[24:20]};
            end
            F_S: begin
                d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = w[14:12];
                d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            F_B: begin
                d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = w[14:12];
                d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            F_U: begin d.rd = w[11:7]; d.imm = {w[31:12], 12'h0}; end
            F_J: begin
                d.rd = w[11:7];
                d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic fields_t mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                   logic [2:0] f3, logic [6:0] f7, logic [31:0] im);
        fields_t f;
        f.opcode = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.funct3 = f3; f.funct7 = f7; f.imm = im;
        return f;
    endfunction

    function automatic logic [6:0] pick_op(int k);
        case (k)
            0: return 7'b0110011;  1: return 7'b0010011;  2: return 7'b0000011;
            3: return 7'b0000111;  4: return 7'b1100111;  5: return 7'b0100011;
            6: return 7'b0100111;  7: return 7'b1100011;  8: return 7'b0110111;
            9: return 7'b0010111; 10: return 7'b1101111;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic fields_t rand_fields();
        fields_t     f;
        logic [31:0] r;
        r = $urandom;
        f = mk(pick_op($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), 32'h0);
        case ($urandom_range(0, 5))
            0:       f.imm = r;
            1:       f.imm = {{20{r[11]}}, r[11:0]};
            2:       f.imm = {{19{r[12]}}, r[12:1], 1'b0};
            3:       f.imm = {{11{r[20]}}, r[20:0]} & 32'hFFFF_FFFE;
            4:       f.imm = {r[19:0], 12'h0};
            default: f.imm = {27'h0, r[4:0]};
        endcase
        return f;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit v, input fields_t f);
        in_valid = v;
        opcode   = f.opcode;
        rd_addr  = f.rd;
        rs1_addr = f.rs1;
        rs2_addr = f.rs2;
        funct3   = f.funct3;
        funct7   = f.funct7;
        imm      = f.imm;
    endtask

    vec_t        vecs[$];
    logic [31:0] exp_addr;
    int          n_rej;

    initial begin
        fields_t     f, m_f, f_addi, f_add, f_bad;
        bit          m_pend, m_flag, v, orr, rs, exp_ready;
        logic [31:0] m_addr;
        int          m_cnt;

        f_addi = mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        f_add  = mk(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
        f_bad  = mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);

        vecs.push_back('{f: f_addi, ok: 1'b1, word: 32'hFFF0_0093, name: "addi_m1"});
        vecs.push_back('{f: mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC), ok: 1'b1, word: 32'hFE20_8EE3, name: "beq_m4"});
        vecs.push_back('{f: mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800), ok: 1'b1, word: 32'h0010_00EF, name: "jal_2048"});
        vecs.push_back('{f: mk(7'b0010011, 5'd5, 5'd5, 5'd0, 3'd5, 7'b0100000, 32'd3), ok: 1'b1, word: 32'h4032_D293, name: "srai_3"});
        vecs.push_back('{f: mk(7'b0010011, 5'd5, 5'd5, 5'd0, 3'd5, 7'b0100000, 32'd32), ok: 1'b0, word: 32'h0, name: "srai_32"});
        vecs.push_back('{f: mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), ok: 1'b0, word: 32'h0, name: "addi_2048"});
        vecs.push_back('{f: mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3), ok: 1'b0, word: 32'h0, name: "jal_3"});
        vecs.push_back('{f: mk(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001), ok: 1'b0, word: 32'h0, name: "lui_1001"});
        vecs.push_back('{f: f_bad, ok: 1'b0, word: 32'h0, name: "op_7f"});
        vecs.push_back('{f: mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), ok: 1'b1, word: 32'h1234_52B7, name: "lui"});
        vecs.push_back('{f: mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), ok: 1'b1, word: 32'h0020_A423, name: "sw_8"});
        vecs.push_back('{f: f_add, ok: 1'b1, word: 32'h0020_81B3, name: "add"});
        vecs.push_back('{f: mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047), ok: 1'b1, word: 32'h7FF0_0093, name: "addi_2047"});
        vecs.push_back('{f: mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800), ok: 1'b1, word: 32'h8000_0093, name: "addi_m2048"});
        vecs.push_back('{f: mk(7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0), ok: 1'b1, word: 32'h0000_8067, name: "jalr"});

        rst = 1'b1; restart = 1'b0; out_ready = 1'b1;
        apply_stimulus(1'b0, f_bad);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("reset out_valid", 64'(out_valid), 64'd0);
        check_output("reset im_wdata", 64'(im_wdata), 64'd0);
        check_output("reset im_addr", 64'(im_addr), 64'(BASE_ADDR));
        check_output("reset err_flag", 64'(err_flag), 64'd0);
        check_output("reset err_cnt", 64'(err_cnt), 64'd0);
        check_output("reset in_ready", 64'(in_ready), 64'd1);

        // Back-to-back vector stream with the memory side always ready.
        exp_addr = BASE_ADDR;
        n_rej    = 0;
        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].f);
            @(negedge clk);
            check_output($sformatf("%s out_valid", vecs[i].name), 64'(out_valid), 64'(vecs[i].ok));
            if (vecs[i].ok) begin
                check_output($sformatf("%s im_wdata", vecs[i].name), 64'(im_wdata), 64'(vecs[i].word));
                check_output($sformatf("%s im_addr", vecs[i].name), 64'(im_addr), 64'(exp_addr));
                exp_addr = exp_addr + 32'd4;
            end else begin
                n_rej++;
            end
        end
        apply_stimulus(1'b0, f_bad);
        @(negedge clk);
        check_output("table drain out_valid", 64'(out_valid), 64'd0);
        check_output("table drain im_addr", 64'(im_addr), 64'(exp_addr));
        check_output("table err_cnt", 64'(err_cnt), 64'(n_rej));
        check_output("table err_flag", 64'(err_flag), 64'd1);

        // Backpressure: word held for five cycles while a new input is offered.
        out_ready = 1'b0;
        apply_stimulus(1'b1, f_addi);
        @(negedge clk);
        check_output("bp out_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b1, f_add);
            #1;
            check_output("bp in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            check_output("bp hold im_wdata", 64'(im_wdata), 64'h0000_0000_FFF0_0093);
            check_output("bp hold im_addr", 64'(im_addr), 64'(exp_addr));
            check_output("bp hold out_valid", 64'(out_valid), 64'd1);
        end
        apply_stimulus(1'b0, f_add);
        out_ready = 1'b1;
        #1;
        check_output("bp release in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check_output("bp release out_valid", 64'(out_valid), 64'd0);
        exp_addr = exp_addr + 32'd4;
        check_output("bp release im_addr", 64'(im_addr), 64'(exp_addr));

        // restart coincident with a rejection clears the error state.
        apply_stimulus(1'b1, f_bad);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        apply_stimulus(1'b0, f_bad);
        check_output("restart+reject err_cnt", 64'(err_cnt), 64'd0);
        check_output("restart+reject err_flag", 64'(err_flag), 64'd0);
        check_output("restart im_addr", 64'(im_addr), 64'(BASE_ADDR));

        out_ready = 1'b0;
        apply_stimulus(1'b1, f_add);
        @(negedge clk);
        apply_stimulus(1'b0, f_add);
        out_ready = 1'b1;
        @(negedge clk);
        check_output("advance im_addr", 64'(im_addr), 64'(BASE_ADDR + 32'd4));
        out_ready = 1'b0;
        apply_stimulus(1'b1, f_addi);
        @(negedge clk);
        apply_stimulus(1'b0, f_addi);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_output("restart hold out_valid", 64'(out_valid), 64'd1);
        check_output("restart hold im_wdata", 64'(im_wdata), 64'h0000_0000_FFF0_0093);
        check_output("restart hold im_addr", 64'(im_addr), 64'(BASE_ADDR));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        apply_stimulus(1'b1, f_add);
        @(negedge clk);
        apply_stimulus(1'b0, f_add);
        check_output("pre-restart im_addr", 64'(im_addr), 64'(BASE_ADDR + 32'd4));
        out_ready = 1'b1;
        restart   = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_output("restart+write im_addr", 64'(im_addr), 64'(BASE_ADDR));
        check_output("restart+write out_valid", 64'(out_valid), 64'd0);

        // Error counter saturation.
        for (int k = 0; k < 260; k++) begin
            apply_stimulus(1'b1, f_bad);
            @(negedge clk);
            if (k == 253) check_output("err_cnt 254", 64'(err_cnt), 64'd254);
        end
        apply_stimulus(1'b0, f_bad);
        @(negedge clk);
        check_output("err_cnt saturate", 64'(err_cnt), 64'd255);
        check_output("saturate out_valid", 64'(out_valid), 64'd0);
        check_output("saturate im_addr", 64'(im_addr), 64'(BASE_ADDR));

        // rst with a pending word discards it and blocks the write.
        out_ready = 1'b0;
        apply_stimulus(1'b1, f_addi);
        @(negedge clk);
        apply_stimulus(1'b0, f_addi);
        check_output("pre-rst out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check_output("rst-cycle write", 64'(out_valid && out_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("post-rst out_valid", 64'(out_valid), 64'd0);
        check_output("post-rst im_wdata", 64'(im_wdata), 64'd0);
        check_output("post-rst im_addr", 64'(im_addr), 64'(BASE_ADDR));
        check_output("post-rst err_cnt", 64'(err_cnt), 64'd0);

        // Randomized run scored by a transaction-level model and field decode.
        m_pend = 1'b0; m_flag = 1'b0; m_cnt = 0; m_addr = BASE_ADDR; m_f = '0;
        for (int c = 0; c < 3000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 49) == 0);
            f   = rand_fields();
            apply_stimulus(v, f);
            out_ready = orr;
            restart   = rs;
            #1;
            exp_ready = !m_pend || orr;
            check_output("rand in_ready", 64'(in_ready), 64'(exp_ready));
            if (m_pend && orr) begin
                m_addr = m_addr + 32'd4;
                m_pend = 1'b0;
            end
            if (v && exp_ready) begin
                if (legal_model(f)) begin
                    m_pend = 1'b1;
                    m_f    = f;
                end else begin
                    m_flag = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            if (rs) begin
                m_addr = BASE_ADDR;
                m_cnt  = 0;
                m_flag = 1'b0;
            end
            @(negedge clk);
            check_output("rand out_valid", 64'(out_valid), 64'(m_pend));
            check_output("rand im_addr", 64'(im_addr), 64'(m_addr));
            check_output("rand err_cnt", 64'(err_cnt), 64'(m_cnt));
            check_output("rand err_flag", 64'(err_flag), 64'(m_flag));
            if (m_pend)
                check_output("rand decoded fields", 64'(canon(decode(im_wdata))), 64'(canon(m_f)));
        end
        restart = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32 instruction encoder: the inverse of the core's decode stage. Accepts instruction fields plus a full 32-bit immediate over a valid/ready handshake, range-checks the immediate for the instruction format, packs a 32-bit instruction word and emits it with a sequential instruction-memory write address. It sits between the boot/program-loader logic and the instruction-memory write port, so test programs can be built from fields in hardware.

## Interface
- BASE_ADDR, 32'h0000_0000: first write address after reset/restart (word aligned).
- ADDR_W, 32: width of im_addr; the address wraps modulo 2^ADDR_W.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- restart  input  1  synchronous; reloads the address counter to BASE_ADDR and clears err_flag and err_cnt; the pipeline register is untouched.
- in_valid  input  1  fields valid.
- in_ready  output  1  encoder can accept this cycle.
- opcode  input  7  instruction opcode (codebase define.svh values).
- rd_addr, rs1_addr, rs2_addr  input  5 each  register fields.
- funct3  input  3; funct7  input  7.
- imm  input  32  full signed immediate (byte offset for B/J).
- out_valid  output  1  encoded word pending.
- out_ready  input  1  memory side accepts.
- im_wdata  output  32  encoded instruction.
- im_addr  output  ADDR_W  write address of im_wdata.
- err_flag  output  1  sticky: at least one input was rejected.
- err_cnt  output  8  rejected inputs, saturates at 255.

## Operation
- Formats: R (0110011) = {funct7,rs2,rs1,funct3,rd,op}. I (Itype, Load, FLW, JALR) = {imm[11:0],rs1,funct3,rd,op}. Itype with funct3 001/101 (shift) = {funct7,imm[4:0],rs1,funct3,rd,op}. S (Store, FSW) = {imm[11:5],rs2,rs1,funct3,imm[4:0],op}. B (Branch) = {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}. U (LUI, AUIPC) = {imm[31:12],rd,op}. J (JAL) = {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Range checks (reject if violated): I/S: imm[31:11] all equal. Shift: imm[31:5]==0. B: imm[31:12] all equal and imm[0]==0. J: imm[31:20] all equal and imm[0]==0. U: imm[11:0]==0. R: imm ignored. Any other opcode: reject.
- Rejected input: consumed (handshake completes), no word produced, address unchanged, err_flag<=1, err_cnt<=err_cnt+1 (saturating).
- Accepted input: loaded into the single output register (im_wdata, out_valid=1).
- Address counter: im_addr<=im_addr+4 on each out_valid&&out_ready cycle; wraps at 2^ADDR_W. im_addr always shows the address of the currently pending word.
- Pipeline state: EMPTY (out_valid=0) / FULL (out_valid=1). EMPTY->FULL on an accepted input; FULL->EMPTY on out_ready with no accepted input; FULL->FULL on out_ready plus an accepted input (back-to-back); FULL holds while out_ready=0.
- in_ready = !out_valid || out_ready (combinational pass-through from out_ready; one word per cycle sustained).
- restart coincident with an output handshake: counter loads BASE_ADDR (restart wins). restart coincident with a rejection: err_cnt=0, err_flag=0 (restart wins).

## Timing
- Reset values: out_valid=0, im_wdata=0, im_addr=BASE_ADDR, err_flag=0, err_cnt=0; in_ready=1 the cycle after reset.
- Latency: input accepted at edge N -> out_valid/im_wdata valid after edge N, i.e. 1 cycle.
- im_wdata and im_addr hold stable while out_valid=1 and out_ready=0.
- rst mid-transfer discards the pending word; no write handshake completes in the rst cycle.
- Inputs sampled only when in_valid&&in_ready; fields otherwise don't-care.

## Test plan
- ADDI x1,x0,-1: opcode 0010011, rd=1, funct3=0, imm=32'hFFFF_FFFF -> im_wdata 32'hFFF00093 at im_addr BASE_ADDR, one cycle later.
- BEQ offset -4 (rs1=1, rs2=2, funct3=0, imm=-4) then JAL x1,+2048 -> 32'hFE208EE3 then 32'h001000EF; addresses BASE, BASE+4; back-to-back with out_ready=1 gives no bubble.
- SRAI x5,x5,3 (funct7=0100000, imm=3) -> 32'h4032D293; SRAI with imm=32 -> rejected, err_cnt=1, address unchanged.
- Range errors: ADDI imm=2048, JAL imm=3, LUI imm=32'h0000_1001, opcode 7'h7F -> four rejections, err_cnt=4, no out_valid.
- Backpressure: out_ready=0 for 5 cycles with word pending -> in_ready=0, im_wdata/im_addr stable; release -> single write, in_ready=1.
- Encode-decode loopback: feed im_wdata into the core decoder for random legal field sets -> recovered fields and imm equal the originals; restart mid-stream returns im_addr to BASE_ADDR and clears err_flag.
